// File: rtl/fetch_pipe_pkg.sv
// fetch_pipe_pkg
//   Shared types and helpers for the instruction-fetch slice.
//   Also carries the global width macros used by the fetch files:
//     LEN_MEM_ADDR   byte-address width
//     LEN_INST       instruction width
//     FETCH_ENTRY_W  packed queue entry width {inst, pc, fault}

`ifndef FETCH_PIPE_WIDTHS_DEFINED
`define FETCH_PIPE_WIDTHS_DEFINED
`define LEN_MEM_ADDR 32
`define LEN_INST 32
`define FETCH_ENTRY_W (`LEN_INST + `LEN_MEM_ADDR + 1)
`endif

package fetch_pipe_pkg;

    // One queued fetch result; field order fixes the packing used by the queue.
    typedef struct packed {
        logic [`LEN_INST-1:0]     inst;
        logic [`LEN_MEM_ADDR-1:0] pc;
        logic                     fault;
    } fetch_entry_t;

    // Instructions are word aligned; any low address bit set is a fetch fault.
    function automatic logic pc_misaligned(input logic [`LEN_MEM_ADDR-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   In-order FIFO holding returned fetch results for the decode stage.
//   Ports:
//     clk, rst    clock (rising edge), asynchronous active-high reset
//     clear       synchronous flush: empties the queue, suppresses push/pop
//     push        write push_data at the tail
//     push_data   entry to write
//     pop         remove the head entry (ignored while empty)
//     count       number of stored entries (0..DEPTH)
//     head        entry at the head (undefined content while empty)
//   DEPTH must be a power of two so the pointers wrap naturally.

module fetch_queue
    import fetch_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~clear & (count != (AW+1)'(DEPTH));
    assign do_pop  = pop & ~clear & (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every use of its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_pipe.sv
// fetch_pipe
//   Pipelined instruction fetcher. Takes one PC per cycle, drives the
//   instruction-memory word address, tracks requests through a fixed-latency
//   memory and queues returned instructions (tagged with PC and fault) in order.
//   Ports:
//     clk, rst      clock (rising edge), asynchronous active-high reset
//     order, pc     fetch request and its byte address
//     accepted      request taken this cycle (combinational)
//     flush         discard every in-flight and queued fetch
//     done          queue head valid
//     take          consumer pops the head when done=1
//     inst, inst_pc, inst_fault   head entry (zero while the queue is empty)
//     a_inst_mem    instruction memory word address = pc[LEN_MEMISTR_ADDR+1:2]
//     d_inst_mem    instruction memory read data, MEM_LATENCY cycles after address

module fetch_pipe
    import fetch_pipe_pkg::*;
#(
    parameter int LEN_MEMISTR_ADDR = 15,
    parameter int MEM_LATENCY      = 2,
    parameter int QUEUE_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        order,
    input  logic [`LEN_MEM_ADDR-1:0]    pc,
    output logic                        accepted,
    input  logic                        flush,
    output logic                        done,
    input  logic                        take,
    output logic [`LEN_INST-1:0]        inst,
    output logic [`LEN_MEM_ADDR-1:0]    inst_pc,
    output logic                        inst_fault,
    output logic [LEN_MEMISTR_ADDR-1:0] a_inst_mem,
    input  logic [`LEN_INST-1:0]        d_inst_mem
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    // Delay line mirroring the memory pipeline: stage i holds the request
    // presented i+1 cycles ago, so the last stage lines up with d_inst_mem.
    logic [MEM_LATENCY-1:0]   dl_valid;
    logic [MEM_LATENCY-1:0]   dl_fault;
    logic [`LEN_MEM_ADDR-1:0] dl_pc [MEM_LATENCY];

    logic [CNT_W-1:0]          q_count;
    logic [`FETCH_ENTRY_W-1:0] q_head;
    fetch_entry_t              head_entry;
    fetch_entry_t              push_entry;
    logic                      q_push;
    logic                      q_pop;
    logic [31:0]               outstanding;

    assign a_inst_mem = pc[LEN_MEMISTR_ADDR+1:2];

    // Credit: every in-flight request already owns a queue slot. The queue
    // count is registered, so a pop frees its slot only from the next cycle.
    always_comb begin
        outstanding = 32'(q_count);
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            outstanding = outstanding + 32'(dl_valid[i]);
        end
    end

    assign accepted = order & ~rst & ~flush & (outstanding < 32'(QUEUE_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            dl_fault <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                dl_pc[i] <= '0;
            end
        end else if (flush) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= accepted;
            dl_pc[0]    <= pc;
            dl_fault[0] <= pc_misaligned(pc);
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_pc[i]    <= dl_pc[i-1];
                dl_fault[i] <= dl_fault[i-1];
            end
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.inst  = d_inst_mem;
        push_entry.pc    = dl_pc[MEM_LATENCY-1];
        push_entry.fault = dl_fault[MEM_LATENCY-1];
    end

    assign q_push = dl_valid[MEM_LATENCY-1] & ~flush;
    assign done   = (q_count != '0);
    assign q_pop  = take & done & ~flush;

    fetch_queue #(
        .WIDTH(`FETCH_ENTRY_W),
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .count     (q_count),
        .head      (q_head)
    );

    // Head fields are masked while empty so no stale storage reaches the outputs.
    assign head_entry = fetch_entry_t'(q_head);
    assign inst       = done ? head_entry.inst  : '0;
    assign inst_pc    = done ? head_entry.pc    : '0;
    assign inst_fault = done ? head_entry.fault : 1'b0;

endmodule
